fetch_unit: RTL and testbench

- Parametrised successor to the current single-cycle PC/next-PC pair.
- Generates sequential fetch addresses and issues them to instruction memory over a valid/ready request channel.
- Buffers in-order responses in a prefetch queue and hands {instruction, pc} to decode over a valid/ready channel.
- Supports branch/jump redirect with flush of queued and in-flight fetches, plus a halt input.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_queue.sv | 59 +++++
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction fetch unit.
// Instructions are fixed 4-byte words, so fetch addresses are always word aligned.
package fetch_pkg;

  localparam int INST_BYTES = 4;
  localparam int PC_INC     = INST_BYTES;

  // Clears the byte-offset bits of an address. Callers truncate the result to their address width.
  function automatic logic [63:0] align_mask();
    return ~64'(INST_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO with flush.
// A push and a pop in the same cycle are both honoured, even when the FIFO is full.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  // Storage is not reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with a credit-limited request channel, an in-order prefetch queue,
// and a redirect path that flushes queued data and discards responses to older requests.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = 32,
  parameter int                DEPTH        = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       halt,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_addr,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [ADDR_W-1:0]          imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [DATA_W-1:0]          imem_rsp_data,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [DATA_W-1:0]          inst_data,
  output logic [ADDR_W-1:0]          inst_pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int                CW         = $clog2(DEPTH+1);
  localparam int                QW         = DATA_W + ADDR_W;
  localparam logic [CW:0]       CREDITS    = DEPTH[CW:0];
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(PC_INC);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(align_mask());

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     drop;
  logic [CW-1:0]     inflight_after_rsp;
  logic [CW:0]       pending_total;

  logic              req_fire;
  logic              rsp_accept;
  logic              rsp_keep;
  logic              rsp_discard;

  logic              q_push;
  logic              q_pop;
  logic              q_full;
  logic              q_empty;
  logic [CW-1:0]     q_count;
  logic [QW-1:0]     q_head;

  // Every issued request reserves a queue slot, so responses can never be back-pressured.
  assign pending_total  = {1'b0, q_count} + {1'b0, inflight};
  assign occupancy      = pending_total[CW-1:0];
  assign imem_req_valid = !rst && !halt && !redirect_valid && (pending_total < CREDITS);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign rsp_accept         = imem_rsp_valid && (inflight != '0);
  assign rsp_keep           = rsp_accept && (drop == '0);
  assign rsp_discard        = rsp_accept && (drop != '0);
  assign inflight_after_rsp = inflight - CW'(rsp_accept);

  assign inst_valid = !q_empty && !redirect_valid;
  assign inst_data  = q_head[QW-1:ADDR_W];
  assign inst_pc    = q_head[ADDR_W-1:0];
  assign q_pop      = inst_valid && inst_ready;
  assign q_push     = rsp_keep && !redirect_valid && (!q_full || q_pop);

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (QW)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data ({imem_rsp_data, rsp_pc}),
    .pop       (q_pop),
    .flush     (redirect_valid),
    .head_data (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  // On redirect every request still outstanding belongs to the old path, so all of them become drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_VECTOR;
      rsp_pc   <= RESET_VECTOR;
      inflight <= '0;
      drop     <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_addr & ALIGN_MASK;
      rsp_pc   <= redirect_addr & ALIGN_MASK;
      inflight <= inflight_after_rsp;
      drop     <= inflight_after_rsp;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + PC_STEP;
      end
      if (rsp_keep) begin
        rsp_pc <= rsp_pc + PC_STEP;
      end
      if (rsp_discard) begin
        drop <= drop - CW'(1);
      end
      inflight <= inflight_after_rsp + CW'(req_fire);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: a latency-configurable memory and a queue-based model of the
// expected instruction stream, driven by directed scenarios and a randomized run.
module tb_fetch_unit;

  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RV     = 32'h0000_0100;
  localparam logic [31:0] XMASK  = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [2:0]  occupancy;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  pend_t       pending[$];
  logic [31:0] prefetch[$];
  logic [31:0] exp_fetch_pc;
  int          cyc;
  int          latency;
  bit          ready_random;
  int          n_checks;
  int          n_pass;

  logic        obs_req_valid;
  logic        obs_req_fire;
  logic [31:0] obs_req_addr;
  logic        obs_inst_valid;
  logic        obs_inst_fire;
  logic [31:0] obs_inst_pc;
  logic [2:0]  obs_occ;

  fetch_unit #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .DEPTH        (DEPTH),
    .RESET_VECTOR (RV)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  // One clock: memory drives its response at the falling edge, outputs are checked against the
  // model, the model advances as the rising edge will, and control returns just after that edge.
  task automatic cycle();
    logic  exp_req_valid;
    logic  exp_inst_valid;
    int    exp_occ;
    pend_t head;
    @(negedge clk);
    if (!rst && pending.size() > 0 && pending[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pending[0].addr ^ XMASK;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    imem_req_ready = ready_random ? ($urandom_range(0, 3) != 0) : 1'b1;
    #1;
    obs_req_valid  = imem_req_valid;
    obs_req_fire   = imem_req_valid && imem_req_ready;
    obs_req_addr   = imem_req_addr;
    obs_inst_valid = inst_valid;
    obs_inst_fire  = inst_valid && inst_ready;
    obs_inst_pc    = inst_pc;
    obs_occ        = occupancy;

    exp_occ        = prefetch.size() + pending.size();
    exp_req_valid  = !rst && !halt && !redirect_valid && (exp_occ < DEPTH);
    exp_inst_valid = (prefetch.size() > 0) && !redirect_valid;
    if (!rst) begin
      n_checks++;
      if (obs_req_valid !== exp_req_valid)
        $display("[TB] FAIL req_valid cyc=%0d got=%b exp=%b", cyc, obs_req_valid, exp_req_valid);
      else n_pass++;
      n_checks++;
      if (obs_occ !== 3'(exp_occ))
        $display("[TB] FAIL occupancy cyc=%0d got=%0d exp=%0d", cyc, obs_occ, exp_occ);
      else n_pass++;
      n_checks++;
      if (obs_inst_valid !== exp_inst_valid)
        $display("[TB] FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, obs_inst_valid, exp_inst_valid);
      else n_pass++;
      if (exp_req_valid) begin
        n_checks++;
        if (obs_req_addr !== exp_fetch_pc)
          $display("[TB] FAIL req_addr cyc=%0d got=%h exp=%h", cyc, obs_req_addr, exp_fetch_pc);
        else n_pass++;
      end
      if (exp_inst_valid) begin
        n_checks++;
        if (inst_pc !== prefetch[0])
          $display("[TB] FAIL inst_pc cyc=%0d got=%h exp=%h", cyc, inst_pc, prefetch[0]);
        else n_pass++;
        n_checks++;
        if (inst_data !== (prefetch[0] ^ XMASK))
          $display("[TB] FAIL inst_data cyc=%0d got=%h exp=%h", cyc, inst_data, prefetch[0] ^ XMASK);
        else n_pass++;
      end
    end

    if (rst) begin
      pending.delete();
      prefetch.delete();
      exp_fetch_pc = RV;
    end else if (redirect_valid) begin
      if (imem_rsp_valid) head = pending.pop_front();
      foreach (pending[i]) pending[i].stale = 1'b1;
      prefetch.delete();
      exp_fetch_pc = redirect_addr & ~32'h3;
    end else begin
      if (exp_inst_valid && inst_ready) void'(prefetch.pop_front());
      if (imem_rsp_valid) begin
        head = pending.pop_front();
        if (!head.stale) prefetch.push_back(head.addr);
      end
      if (exp_req_valid && imem_req_ready) begin
        pending.push_back('{addr: exp_fetch_pc, due: cyc + latency, stale: 1'b0});
        exp_fetch_pc = exp_fetch_pc + 32'd4;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    latency      = 1;
    ready_random = 1'b0;
    inst_ready   = 1'b1;
    rst          = 1'b1;
    cycle();
    n_checks++;
    if (obs_req_valid !== 1'b0) $display("[TB] FAIL reset_req_valid got=%b exp=0", obs_req_valid);
    else n_pass++;
    cycle();
    rst  = 1'b0;
    halt = 1'b1;
    cycle();
    n_checks++;
    if (obs_occ !== 3'd0) $display("[TB] FAIL reset_occupancy got=%0d exp=0", obs_occ);
    else n_pass++;
    n_checks++;
    if (obs_inst_valid !== 1'b0) $display("[TB] FAIL reset_inst_valid got=%b exp=0", obs_inst_valid);
    else n_pass++;
    halt = 1'b0;
  endtask

  task automatic test_latency();
    int first_inst;
    int delivered;
    latency      = 1;
    ready_random = 1'b0;
    inst_ready   = 1'b1;
    do_reset();
    first_inst = -1;
    delivered  = 0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (k == 0) begin
        n_checks++;
        if (!(obs_req_fire && obs_req_addr == RV))
          $display("[TB] FAIL first_request got=%b/%h exp=1/%h", obs_req_fire, obs_req_addr, RV);
        else n_pass++;
      end
      if (obs_inst_fire) begin
        if (first_inst < 0) first_inst = k;
        delivered++;
      end
    end
    n_checks++;
    if (first_inst != 2) $display("[TB] FAIL first_inst_cycle got=%0d exp=2", first_inst);
    else n_pass++;
    n_checks++;
    if (delivered != 10) $display("[TB] FAIL throughput got=%0d exp=10", delivered);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int fires;
    int got;
    latency      = 1;
    ready_random = 1'b0;
    inst_ready   = 1'b0;
    do_reset();
    fires = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (obs_req_fire) fires++;
    end
    n_checks++;
    if (fires != DEPTH) $display("[TB] FAIL stall_requests got=%0d exp=%0d", fires, DEPTH);
    else n_pass++;
    n_checks++;
    if (obs_occ !== 3'(DEPTH)) $display("[TB] FAIL stall_occupancy got=%0d exp=%0d", obs_occ, DEPTH);
    else n_pass++;
    n_checks++;
    if (obs_req_valid !== 1'b0) $display("[TB] FAIL stall_req_valid got=%b exp=0", obs_req_valid);
    else n_pass++;
    inst_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 20 && got < 4; k++) begin
      cycle();
      if (obs_inst_fire) begin
        n_checks++;
        if (obs_inst_pc !== RV + 32'(4 * got))
          $display("[TB] FAIL release_order got=%h exp=%h", obs_inst_pc, RV + 32'(4 * got));
        else n_pass++;
        got++;
      end
    end
    n_checks++;
    if (got != 4) $display("[TB] FAIL release_count got=%0d exp=4", got);
    else n_pass++;
  endtask

  task automatic test_redirect_drop();
    bit found;
    latency      = 3;
    ready_random = 1'b0;
    inst_ready   = 1'b1;
    do_reset();
    cycle();
    cycle();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0000_2003;
    cycle();
    redirect_valid = 1'b0;
    n_checks++;
    if (obs_req_valid !== 1'b0 || obs_inst_valid !== 1'b0)
      $display("[TB] FAIL redirect_quiet got=%b/%b exp=0/0", obs_req_valid, obs_inst_valid);
    else n_pass++;
    cycle();
    n_checks++;
    if (!(obs_req_valid && obs_req_addr == 32'h2000))
      $display("[TB] FAIL redirect_target got=%b/%h exp=1/00002000", obs_req_valid, obs_req_addr);
    else n_pass++;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      if (obs_inst_valid) begin
        found = 1'b1;
        n_checks++;
        if (obs_inst_pc !== 32'h2000) $display("[TB] FAIL redirect_first_pc got=%h exp=00002000", obs_inst_pc);
        else n_pass++;
      end
    end
    if (!found) begin
      n_checks++;
      $display("[TB] FAIL redirect_timeout got=no inst_valid exp=inst_valid within 20 cycles");
    end
  endtask

  task automatic test_redirect_collision();
    bit found;
    latency      = 1;
    ready_random = 1'b0;
    inst_ready   = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) cycle();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0000_3000;
    cycle();
    redirect_valid = 1'b0;
    n_checks++;
    if (obs_inst_valid !== 1'b0) $display("[TB] FAIL collision_inst_valid got=%b exp=0", obs_inst_valid);
    else n_pass++;
    cycle();
    n_checks++;
    if (obs_occ !== 3'd0) $display("[TB] FAIL collision_occupancy got=%0d exp=0", obs_occ);
    else n_pass++;
    n_checks++;
    if (obs_req_addr !== 32'h3000) $display("[TB] FAIL collision_target got=%h exp=00003000", obs_req_addr);
    else n_pass++;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle();
      if (obs_inst_valid) begin
        found = 1'b1;
        n_checks++;
        if (obs_inst_pc !== 32'h3000) $display("[TB] FAIL collision_first_pc got=%h exp=00003000", obs_inst_pc);
        else n_pass++;
      end
    end
    if (!found) begin
      n_checks++;
      $display("[TB] FAIL collision_timeout got=no inst_valid exp=inst_valid within 10 cycles");
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr [3];
    int          got;
    exp_addr[0]  = 32'hFFFF_FFF8;
    exp_addr[1]  = 32'hFFFF_FFFC;
    exp_addr[2]  = 32'h0000_0000;
    latency      = 1;
    ready_random = 1'b0;
    inst_ready   = 1'b1;
    do_reset();
    redirect_valid = 1'b1;
    redirect_addr  = 32'hFFFF_FFF8;
    cycle();
    redirect_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 10 && got < 3; k++) begin
      cycle();
      if (obs_req_fire) begin
        n_checks++;
        if (obs_req_addr !== exp_addr[got])
          $display("[TB] FAIL wrap_addr got=%h exp=%h", obs_req_addr, exp_addr[got]);
        else n_pass++;
        got++;
      end
    end
    for (int k = 0; k < 4; k++) cycle();
  endtask

  task automatic test_halt_reset();
    latency      = 3;
    ready_random = 1'b0;
    inst_ready   = 1'b0;
    do_reset();
    cycle();
    cycle();
    halt = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      n_checks++;
      if (obs_req_valid !== 1'b0) $display("[TB] FAIL halt_req_valid got=%b exp=0", obs_req_valid);
      else n_pass++;
    end
    n_checks++;
    if (obs_occ !== 3'd2 || obs_inst_valid !== 1'b1)
      $display("[TB] FAIL halt_landed got=%0d/%b exp=2/1", obs_occ, obs_inst_valid);
    else n_pass++;
    halt = 1'b0;
    cycle();
    n_checks++;
    if (!(obs_req_valid && obs_req_addr == 32'h108))
      $display("[TB] FAIL halt_resume got=%b/%h exp=1/00000108", obs_req_valid, obs_req_addr);
    else n_pass++;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    n_checks++;
    if (obs_occ !== 3'd0 || obs_inst_valid !== 1'b0)
      $display("[TB] FAIL midstream_reset got=%0d/%b exp=0/0", obs_occ, obs_inst_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    latency      = $urandom_range(1, 4);
    ready_random = 1'b1;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rst            = ($urandom_range(0, 299) == 0);
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_addr  = $urandom;
      inst_ready     = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) halt = ~halt;
      cycle();
    end
    rst            = 1'b0;
    redirect_valid = 1'b0;
    halt           = 1'b0;
    ready_random   = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    cyc            = 0;
    latency        = 1;
    ready_random   = 1'b0;
    rst            = 1'b1;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    exp_fetch_pc   = RV;
    @(posedge clk);
    #1;
    test_reset();
    test_latency();
    test_backpressure();
    test_redirect_drop();
    test_redirect_collision();
    test_wrap();
    test_halt_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
